// File: rtl/lcd_bus_writer.sv
// Pops bytes from the upstream byte queue and writes them to a 12864B-style
// parallel LCD bus; an ESC prefix turns the following byte into a command.
module lcd_bus_writer #(
  parameter int         T_INIT  = 2_500_000,
  parameter int         T_AS    = 2,
  parameter int         T_EH    = 12,
  parameter int         T_H     = 2,
  parameter int         T_EXEC  = 4000,
  parameter int         T_CLEAR = 80000,
  parameter logic [7:0] ESC     = 8'hFE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] qcount,
  input  logic [7:0] out_queue,
  output logic       query,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_INIT, T_AS), max2(T_EH, T_H)),
                              max2(T_EXEC, T_CLEAR));
  localparam int CW    = $clog2(T_MAX + 1);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CW-1:0] C_INIT  = CW'(T_INIT - 1);
  localparam logic [CW-1:0] C_AS    = CW'(T_AS - 1);
  localparam logic [CW-1:0] C_EH    = CW'(T_EH - 1);
  localparam logic [CW-1:0] C_H     = CW'(T_H - 1);
  localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_CLEAR = CW'(T_CLEAR - 1);

  typedef enum logic [3:0] {
    INIT_WAIT,
    IDLE,
    QRY,
    QWAIT,
    GET,
    SETUP,
    STROBE,
    HOLD,
    EXEC
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            esc_pending_reg;
  logic            long_exec_reg;
  logic            cnt_zero;

  assign cnt_zero = (cnt_reg == '0);
  assign lcd_rw   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= INIT_WAIT;
      cnt_reg         <= C_INIT;
      esc_pending_reg <= 1'b0;
      long_exec_reg   <= 1'b0;
      query           <= 1'b0;
      lcd_rs          <= 1'b0;
      lcd_e           <= 1'b0;
      lcd_db          <= 8'h00;
      busy            <= 1'b1;
    end else begin
      case (state_reg)
        INIT_WAIT: begin
          if (cnt_zero) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        IDLE: begin
          if (qcount != 8'h00) begin
            query     <= 1'b1;
            busy      <= 1'b1;
            state_reg <= QRY;
          end
        end

        QRY: begin
          query     <= 1'b0;
          state_reg <= QWAIT;
        end

        // The queue needs one extra cycle to present the popped head.
        QWAIT: state_reg <= GET;

        GET: begin
          if (!esc_pending_reg && out_queue == ESC) begin
            esc_pending_reg <= 1'b1;
            busy            <= 1'b0;
            state_reg       <= IDLE;
          end else begin
            // Only an escaped non-ESC byte is a command; ESC,ESC is literal data.
            lcd_db          <= out_queue;
            lcd_rs          <= !(esc_pending_reg && out_queue != ESC);
            long_exec_reg   <= esc_pending_reg &&
                               (out_queue inside {8'h01, 8'h02, 8'h03});
            esc_pending_reg <= 1'b0;
            cnt_reg         <= C_AS;
            state_reg       <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_zero) begin
            lcd_e     <= 1'b1;
            cnt_reg   <= C_EH;
            state_reg <= STROBE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        STROBE: begin
          if (cnt_zero) begin
            lcd_e     <= 1'b0;
            cnt_reg   <= C_H;
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        HOLD: begin
          if (cnt_zero) begin
            cnt_reg   <= long_exec_reg ? C_CLEAR : C_EXEC;
            state_reg <= EXEC;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        EXEC: begin
          if (cnt_zero) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= INIT_WAIT;
          cnt_reg   <= C_INIT;
          query     <= 1'b0;
          lcd_e     <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
